clk_div_multi: RTL
==================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 32: divisor and counter width.
REQ-003 Parameter CH_W, default 2: channel-select width, with 2**CH_W >= NUM_CH.
REQ-004 Parameter DEFAULT_DIV, default 500000: divisor loaded into every channel at reset.
REQ-005 Clk_xi  in  1: single clock; all logic on its rising edge.
REQ-006 Rst_n  in  1: reset, asynchronous and active-low.
REQ-007 En_xi  in  NUM_CH: per-channel run enable.
REQ-008 Div_xi  in  CNT_W: divisor write data.
REQ-009 Div_ch_xi  in  CH_W: divisor write channel select.
REQ-010 Div_wr_xi  in  1: divisor write strobe, one cycle per write.
REQ-011 Div_ack_xo  out  1: one-cycle write-accepted pulse.
REQ-012 Sync_xi  in  1: phase-align strobe for all channels.
REQ-013 Clk_xo  out  NUM_CH: divided clock per channel.
REQ-014 Tick_xo  out  NUM_CH: one-cycle pulse per channel on every Clk_xo toggle.

Function
REQ-015 Each channel SHALL hold an active divisor Div_cur, a pending divisor Div_pend with a pending flag, a counter Cnt, and the Clk_xo/Tick_xo registers.
REQ-016 Channel running (En_xi[i]=1) and Cnt==Div_cur: Cnt <= 0, Clk_xo[i] toggles, Tick_xo[i] <= 1 for that cycle.
REQ-017 Channel running and Cnt!=Div_cur: Cnt <= Cnt+1, Tick_xo[i] <= 0.
REQ-018 Output half-period SHALL be Div_cur+1 input cycles; full period 2*(Div_cur+1).
REQ-019 Div_cur==0 SHALL toggle Clk_xo[i] every cycle (Clk_xi/2), with Tick_xo[i] held high continuously.
REQ-020 En_xi[i]=0: Cnt and Clk_xo[i] hold, Tick_xo[i] <= 0; running resumes from the held Cnt.
REQ-021 Div_wr_xi=1 with Div_ch_xi<NUM_CH: Div_pend[ch] <= Div_xi, pending set, Div_ack_xo=1 on the next cycle.
REQ-022 Div_wr_xi=1 with Div_ch_xi>=NUM_CH: write ignored, no ack.
REQ-023 Write to a channel whose pending flag is already set: Div_pend overwritten (last write wins), ack issued.
REQ-024 Pending divisor SHALL transfer to Div_cur only in a cycle where the REQ-016 terminal condition holds (pending cleared), so no runt half-period occurs.
REQ-025 Write and terminal condition on the same channel in the same cycle: the terminal uses the old Div_cur; the new value becomes pending and applies at the next terminal.
REQ-026 Disabled channel: a pending divisor stays pending until the channel runs and reaches terminal.
REQ-027 Sync_xi=1 (priority over REQ-016/017/020): every channel Cnt <= 0, Clk_xo <= 0, Tick_xo <= 0, any pending divisor moves to Div_cur immediately, regardless of En_xi.
REQ-028 Sync_xi and Div_wr_xi in the same cycle: the written value SHALL become Div_cur of the addressed channel directly, pending cleared, ack still issued.
REQ-029 Counter SHALL never exceed Div_cur, so no wrap-around beyond CNT_W is possible; arithmetic is unsigned CNT_W.

Reset
REQ-030 Rst_n=0 SHALL asynchronously set, per channel: Cnt=0, Clk_xo=0, Tick_xo=0, Div_cur=DEFAULT_DIV, pending cleared; also Div_ack_xo=0.
REQ-031 Reset asserted mid-period SHALL abort the period; after release, the first toggle occurs DEFAULT_DIV+1 running cycles later.

Verification (bench: NUM_CH=4, CNT_W=8, DEFAULT_DIV=3)
REQ-032 Reset release, all En=1 -> every Clk_xo rises at cycle 4 and falls at cycle 8 (period 8); Tick high at cycles 4 and 8.
REQ-033 Write Div=1 to ch2 at cycle 2 -> ack at cycle 3; ch2 keeps half-period 4 until its first terminal, then period 4; other channels unchanged.
REQ-034 Write Div=0 to ch1, then Sync -> ch1 Clk_xo toggles every cycle from the cycle after Sync; Tick_xo[1] is stuck high.
REQ-035 En[0] low for 5 cycles at Cnt=2 -> Clk_xo[0] frozen; after re-enable it toggles 2 cycles later (Cnt 2->3, terminal).
REQ-036 Write with Div_ch_xi=3 vs a 4th channel index out of range (NUM_CH=3 build) -> no ack, no divisor change; two back-to-back writes to ch0 (5, then 7) -> Div_cur becomes 7.
REQ-037 Rst_n pulsed low at Cnt=2 with Clk_xo=1 -> Clk_xo=0 immediately, without waiting for a clock edge; the next toggle comes 4 cycles after release.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel toggles Clk_xo every Div_cur+1 enabled cycles.
// Divisor updates are staged and take effect only at a half-period boundary, or at once on Sync_xi.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 500000
) (
  input  logic              Clk_xi,
  input  logic              Rst_n,
  input  logic [NUM_CH-1:0] En_xi,
  input  logic [CNT_W-1:0]  Div_xi,
  input  logic [CH_W-1:0]   Div_ch_xi,
  input  logic              Div_wr_xi,
  output logic              Div_ack_xo,
  input  logic              Sync_xi,
  output logic [NUM_CH-1:0] Clk_xo,
  output logic [NUM_CH-1:0] Tick_xo
);

  logic wr_vld;

  // Writes addressed beyond the last channel are dropped and never acknowledged.
  assign wr_vld = Div_wr_xi && (int'(Div_ch_xi) < NUM_CH);

  always_ff @(posedge Clk_xi or negedge Rst_n) begin
    if (!Rst_n) begin
      Div_ack_xo <= 1'b0;
    end else begin
      Div_ack_xo <= wr_vld;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] cnt;
    logic             pend_vld;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             term;

    assign wr_hit = wr_vld && (Div_ch_xi == CH_W'(g));
    assign term   = (cnt == div_cur);

    always_ff @(posedge Clk_xi or negedge Rst_n) begin
      if (!Rst_n) begin
        div_cur  <= CNT_W'(DEFAULT_DIV);
        div_pend <= '0;
        pend_vld <= 1'b0;
        cnt      <= '0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else if (Sync_xi) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        // A write arriving with the sync is newer than anything already pending.
        if (wr_hit) begin
          div_cur  <= Div_xi;
          pend_vld <= 1'b0;
        end else if (pend_vld) begin
          div_cur  <= div_pend;
          pend_vld <= 1'b0;
        end
      end else begin
        if (En_xi[g]) begin
          if (term) begin
            cnt    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
            if (pend_vld) begin
              div_cur  <= div_pend;
              pend_vld <= 1'b0;
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
        // Placed last so a write coinciding with a terminal stays pending for the next one.
        if (wr_hit) begin
          div_pend <= Div_xi;
          pend_vld <= 1'b1;
        end
      end
    end

    assign Clk_xo[g]  = clk_q;
    assign Tick_xo[g] = tick_q;
  end

endmodule
